// File: rtl/iob_fifo_reader_pkg.sv
// iob_fifo_reader_pkg
//   Shared constants and helpers for the FIFO drain engine.
//   OCC_W     : width of the 2-entry word-buffer occupancy count (0..2).
//   sel_width : beat-select width, at least one bit even when RATIO is 1.
package iob_fifo_reader_pkg;

    localparam int unsigned OCC_W = 2;

    function automatic int unsigned sel_width(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/iob_fifo_reader_buf.sv
// iob_fifo_reader_buf
//   Two-entry word buffer (head/tail) that absorbs the one-cycle FIFO read
//   latency. The head word is always the one being serialized.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     push     : write din into the next free slot (after any same-cycle pop)
//     pop      : discard the head word
//     din      : word to write
//     head     : current head word
//     occ      : number of valid words, 0..2
module iob_fifo_reader_buf
    import iob_fifo_reader_pkg::*;
#(
    parameter int unsigned FIFO_DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [FIFO_DATA_W-1:0] din,
    output logic [FIFO_DATA_W-1:0] head,
    output logic [OCC_W-1:0]       occ
);

    logic [FIFO_DATA_W-1:0] head_q;
    logic [FIFO_DATA_W-1:0] tail_q;
    logic [OCC_W-1:0]       occ_q;

    // Push into a full buffer without a pop cannot occur: the top-level
    // credit rule never issues a read that would overrun two entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == OCC_W'(0)) head_q <= din;
                    else                    tail_q <= din;
                    if (occ_q != OCC_W'(2)) occ_q <= occ_q + OCC_W'(1);
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ_q  <= occ_q - OCC_W'(1);
                end
                2'b11: begin
                    // occ unchanged: tail advances to head, new word lands behind it
                    if (occ_q == OCC_W'(2)) begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end else begin
                        head_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = head_q;
    assign occ  = occ_q;

endmodule

// File: rtl/iob_fifo_reader.sv
// iob_fifo_reader
//   Drains a FIFO read port (data valid one cycle after the strobe) into a
//   valid/ready stream of OUT_DATA_W beats, LSB beat of each word first,
//   and flags every pkt_len-th beat with out_last.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     en           : allow new FIFO reads (buffered data drains regardless)
//     pkt_len      : beats per packet, 0 disables out_last
//     fifo_empty   : FIFO empty flag
//     fifo_read_en : FIFO read strobe
//     fifo_data    : FIFO read data, valid the cycle after the strobe
//     out_valid    : beat available
//     out_ready    : consumer accepts the beat
//     out_data     : current beat
//     out_last     : final beat of a packet
module iob_fifo_reader
    import iob_fifo_reader_pkg::*;
#(
    parameter int unsigned FIFO_DATA_W = 32,
    parameter int unsigned OUT_DATA_W  = 8,
    parameter int unsigned LEN_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [LEN_W-1:0]       pkt_len,
    input  logic                   fifo_empty,
    output logic                   fifo_read_en,
    input  logic [FIFO_DATA_W-1:0] fifo_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_DATA_W-1:0]  out_data,
    output logic                   out_last
);

    localparam int unsigned RATIO = FIFO_DATA_W / OUT_DATA_W;
    localparam int unsigned SEL_W = sel_width(RATIO);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(RATIO - 1);

    if ((RATIO * OUT_DATA_W != FIFO_DATA_W) || ((RATIO & (RATIO - 1)) != 0)) begin : g_bad_ratio
        $error("iob_fifo_reader: FIFO_DATA_W/OUT_DATA_W must be a power-of-2 integer");
    end

    logic                   inflight;
    logic [SEL_W-1:0]       sel;
    logic [LEN_W-1:0]       bcnt;
    logic [FIFO_DATA_W-1:0] head;
    logic [OCC_W-1:0]       occ;
    logic                   xfer;
    logic                   pop;
    logic [OCC_W:0]         credit;
    logic [LEN_W-1:0]       len_last;

    iob_fifo_reader_buf #(
        .FIFO_DATA_W (FIFO_DATA_W)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (inflight),
        .pop  (pop),
        .din  (fifo_data),
        .head (head),
        .occ  (occ)
    );

    assign out_valid = (occ != OCC_W'(0));
    assign xfer      = out_valid & out_ready;
    assign pop       = xfer & (sel == SEL_LAST);
    assign len_last  = pkt_len - LEN_W'(1);

    // Words held or arriving after this cycle's pop. pop implies occ>0, so
    // this never underflows. out_ready reaches fifo_read_en through pop so a
    // RATIO=1 stream can sustain one word per cycle.
    assign credit = {1'b0, occ} + (OCC_W+1)'(inflight) - (OCC_W+1)'(pop);

    assign fifo_read_en = ~rst & en & ~fifo_empty & (credit < (OCC_W+1)'(2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            sel      <= '0;
            bcnt     <= '0;
        end else begin
            inflight <= fifo_read_en;
            if (xfer) begin
                sel <= (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
            end
            if (pkt_len == '0) begin
                bcnt <= '0;
            end else if (xfer) begin
                bcnt <= (bcnt == len_last) ? '0 : bcnt + LEN_W'(1);
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (sel == SEL_W'(i)) out_data = head[i*OUT_DATA_W +: OUT_DATA_W];
        end
    end

    assign out_last = out_valid & (pkt_len != '0) & (bcnt == len_last);

endmodule

// File: tb/tb_iob_fifo_reader.sv
// tb_iob_fifo_reader
//   Directed bench: a 32->8 instance (RATIO=4) and an 8->8 instance
//   (RATIO=1), each fed by a small behavioural FIFO with one-cycle read data.
module tb_iob_fifo_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // RATIO=4 instance
    logic        en = 1'b0;
    logic [15:0] pkt_len = '0;
    logic        fifo_empty;
    logic        fifo_read_en;
    logic [31:0] fifo_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;

    // RATIO=1 instance
    logic        en_1 = 1'b0;
    logic [15:0] pkt_len_1 = '0;
    logic        fifo_empty_1;
    logic        fifo_read_en_1;
    logic [7:0]  fifo_data_1;
    logic        out_valid_1;
    logic        out_ready_1 = 1'b0;
    logic [7:0]  out_data_1;
    logic        out_last_1;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    iob_fifo_reader #(.FIFO_DATA_W(32), .OUT_DATA_W(8), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .pkt_len(pkt_len),
        .fifo_empty(fifo_empty), .fifo_read_en(fifo_read_en), .fifo_data(fifo_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    iob_fifo_reader #(.FIFO_DATA_W(8), .OUT_DATA_W(8), .LEN_W(16)) dut1 (
        .clk(clk), .rst(rst), .en(en_1), .pkt_len(pkt_len_1),
        .fifo_empty(fifo_empty_1), .fifo_read_en(fifo_read_en_1), .fifo_data(fifo_data_1),
        .out_valid(out_valid_1), .out_ready(out_ready_1), .out_data(out_data_1), .out_last(out_last_1)
    );

    // Behavioural FIFOs: contents and fill level written by the stimulus,
    // read pointer advanced by the strobe and cleared by the shared reset.
    logic [31:0] mem [0:15];
    int          wr_cnt = 0;
    int          rd_ptr;
    logic [7:0]  mem1 [0:15];
    int          wr_cnt_1 = 0;
    int          rd_ptr_1;

    assign fifo_empty   = (rd_ptr >= wr_cnt);
    assign fifo_empty_1 = (rd_ptr_1 >= wr_cnt_1);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= 0;
            fifo_data <= '0;
        end else if (fifo_read_en) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_1    <= 0;
            fifo_data_1 <= '0;
        end else if (fifo_read_en_1) begin
            fifo_data_1 <= mem1[rd_ptr_1];
            rd_ptr_1    <= rd_ptr_1 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en      = 1'b0;
        en_1    = 1'b0;
        out_ready = 1'b0;
        rst     = 1'b1;
        step();
        step();
        rst     = 1'b0;
        wr_cnt  = 0;
        #1;
    endtask

    task automatic load4(input logic [31:0] w0, w1, w2, w3, input int n);
        mem[0] = w0;
        mem[1] = w1;
        mem[2] = w2;
        mem[3] = w3;
        wr_cnt = n;
    endtask

    // Two words 0x44332211, 0x88776655 drained with out_ready=1
    task automatic run_ser(input logic [15:0] plen);
        logic exp_last;
        do_reset();
        load4(32'h44332211, 32'h88776655, 32'h0, 32'h0, 2);
        pkt_len   = plen;
        out_ready = 1'b1;
        en        = 1'b1;
        #1;
        check($sformatf("ser%0d_re_c0", plen), fifo_read_en, 1);
        check($sformatf("ser%0d_valid_c0", plen), out_valid, 0);
        step();
        check($sformatf("ser%0d_valid_c1", plen), out_valid, 0);
        check($sformatf("ser%0d_re_c1", plen), fifo_read_en, 1);
        for (int i = 0; i < 8; i++) begin
            step();
            exp_last = (plen != 0) && ((i % plen) == plen - 1);
            check($sformatf("ser%0d_valid_b%0d", plen, i), out_valid, 1);
            check($sformatf("ser%0d_data_b%0d", plen, i), out_data, (i + 1) * 8'h11);
            check($sformatf("ser%0d_last_b%0d", plen, i), out_last, exp_last);
            if (i == 0) check($sformatf("ser%0d_re_empty", plen), fifo_read_en, 0);
        end
        step();
        check($sformatf("ser%0d_valid_end", plen), out_valid, 0);
        check($sformatf("ser%0d_last_end", plen), out_last, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        #1;
        check("rst_re", fifo_read_en, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_re_r1", fifo_read_en_1, 0);

        // Serialization with packet marking every 3 beats, then disabled
        run_ser(16'd3);
        run_ser(16'd0);

        // Backpressure: out_ready low while the buffer fills
        do_reset();
        load4(32'h04030201, 32'h08070605, 32'h0c0b0a09, 32'h100f0e0d, 4);
        en = 1'b1;
        #1;
        check("bp_re_c0", fifo_read_en, 1);
        step();
        check("bp_re_c1", fifo_read_en, 1);
        step();
        check("bp_re_c2", fifo_read_en, 0);
        check("bp_data_c2", out_data, 8'h01);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("bp_hold_re_%0d", i), fifo_read_en, 0);
            check($sformatf("bp_hold_data_%0d", i), out_data, 8'h01);
            check($sformatf("bp_hold_valid_%0d", i), out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("bp_valid_b%0d", i), out_valid, 1);
            check($sformatf("bp_data_b%0d", i), out_data, i + 1);
            step();
        end
        check("bp_valid_end", out_valid, 0);

        // Reset mid-stream with the buffer full
        do_reset();
        load4(32'h04030201, 32'h08070605, 32'h0c0b0a09, 32'h100f0e0d, 4);
        pkt_len = 16'd1;
        en      = 1'b1;
        #1;
        step();
        step();
        step();
        check("mr_valid_pre", out_valid, 1);
        check("mr_last_pre", out_last, 1);
        rst = 1'b1;
        #1;
        check("mr_re_in_rst", fifo_read_en, 0);
        step();
        check("mr_valid", out_valid, 0);
        check("mr_data", out_data, 0);
        check("mr_last", out_last, 0);
        check("mr_re", fifo_read_en, 0);
        en  = 1'b0;
        rst = 1'b0;
        pkt_len = 16'd0;
        load4(32'hddccbbaa, 32'h0, 32'h0, 32'h0, 1);
        out_ready = 1'b1;
        en = 1'b1;
        #1;
        step();
        step();
        check("mr_new_b0", out_data, 8'haa);
        step();
        check("mr_new_b1", out_data, 8'hbb);
        step();
        check("mr_new_b2", out_data, 8'hcc);
        step();
        check("mr_new_b3", out_data, 8'hdd);
        step();
        check("mr_new_end", out_valid, 0);

        // en dropped the cycle after a read
        do_reset();
        load4(32'h04030201, 32'h08070605, 32'h0c0b0a09, 32'h0, 3);
        out_ready = 1'b1;
        en = 1'b1;
        #1;
        check("en_re_c0", fifo_read_en, 1);
        step();
        en = 1'b0;
        #1;
        check("en_re_c1", fifo_read_en, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("en_valid_b%0d", i), out_valid, 1);
            check($sformatf("en_data_b%0d", i), out_data, i + 1);
            check($sformatf("en_re_b%0d", i), fifo_read_en, 0);
        end
        step();
        check("en_valid_drained", out_valid, 0);
        check("en_re_drained", fifo_read_en, 0);
        step();
        check("en_re_idle", fifo_read_en, 0);
        en = 1'b1;
        #1;
        check("en_re_back", fifo_read_en, 1);
        step();
        step();
        check("en_next_word", out_data, 8'h05);

        // RATIO=1 full throughput on the second instance
        do_reset();
        for (int i = 0; i < 16; i++) mem1[i] = 8'(i * 7 + 3);
        wr_cnt_1    = 16;
        out_ready_1 = 1'b1;
        en_1        = 1'b1;
        #1;
        for (int c = 0; c < 19; c++) begin
            check($sformatf("r1_re_c%0d", c), fifo_read_en_1, (c < 16) ? 1 : 0);
            check($sformatf("r1_valid_c%0d", c), out_valid_1, (c >= 2 && c < 18) ? 1 : 0);
            if (c >= 2 && c < 18) check($sformatf("r1_data_c%0d", c), out_data_1, (c - 2) * 7 + 3);
            check($sformatf("r1_last_c%0d", c), out_last_1, 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/iob_fifo_reader.md
# iob_fifo_reader

Single-clock drain engine for the read port of the team's FIFOs (sync or async, read side). It issues read strobes against a FIFO whose data appears one cycle after the strobe, absorbs that latency in a 2-word buffer, and presents a valid/ready stream. Each FIFO word is split into RATIO narrower beats, LSB first, and the block marks packet boundaries with a programmable beat count. It sits between a FIFO read port and a byte- or halfword-oriented consumer, such as a UART TX or a DMA write-back.

## Interface
- FIFO_DATA_W, 32, FIFO word width; integer multiple of OUT_DATA_W.
- OUT_DATA_W, 8, output beat width.
- LEN_W, 16, width of the packet-length input and of the beat counter.
- RATIO, FIFO_DATA_W/OUT_DATA_W (derived), must be a power of 2 (1 allowed).
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  allow new FIFO reads; in-flight and buffered data still drain when low.
- pkt_len  in  LEN_W  beats per packet; 0 means out_last is never asserted; must be stable while out_valid=1.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read_en  out  1  FIFO read strobe.
- fifo_data  in  FIFO_DATA_W  FIFO read data, valid the cycle after fifo_read_en.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  OUT_DATA_W  current beat.
- out_last  out  1  final beat of the packet.

## Operation
- State:
  - 2-entry word buffer (head/tail) with occupancy occ in 0..2.
  - inflight flag: a read was issued last cycle.
  - beat select sel in 0..RATIO-1.
  - beat counter bcnt in 0..pkt_len-1.
- Beat handshake: a beat transfers when out_valid and out_ready are both high (`xfer`).
- Pop: the head word is popped when `xfer` occurs with sel==RATIO-1.
- Read issue: fifo_read_en = ~rst & en & ~fifo_empty & ((occ + inflight - pop) < 2). This is combinational, and the out_ready→fifo_read_en path is intentional; it is what allows 1 word/cycle at RATIO=1.
- Capture: inflight is set to the current cycle's fifo_read_en. When inflight=1, fifo_data is written into the buffer next free slot (after any same-cycle pop). The block never overruns because of the credit rule.
- Output:
  - out_valid = (occ != 0).
  - out_data = head[sel*OUT_DATA_W +: OUT_DATA_W].
- Beat select: on `xfer`, sel increments and wraps to 0 after RATIO-1. For RATIO=1, sel is constant 0.
- Beat counter: on `xfer`, bcnt increments and wraps to 0 after pkt_len-1.
  - out_last = out_valid & (pkt_len != 0) & (bcnt == pkt_len-1).
  - If pkt_len == 0, bcnt holds at 0.
- Holding: out_data and out_last hold stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop: occ is unchanged, the tail moves to head, and the new word goes to tail.
- en deasserted: no new reads. The pending in-flight word is still captured, and the buffer drains normally.
- fifo_empty high with inflight=1: the captured word is still valid, because the FIFO gated the read on its own side.

## Timing
- Reset values:
  - occ=0, inflight=0, sel=0, bcnt=0.
  - Buffer cleared to 0.
  - out_valid=0, out_data=0, out_last=0.
  - fifo_read_en=0 while rst=1.
- Reset mid-operation: buffered and in-flight words are discarded. rst is shared with the FIFO, so its pointers reset too.
- Latency: the first beat reaches out_valid 2 cycles after fifo_read_en is first asserted (cycle 0 strobe, cycle 1 capture, cycle 2 visible).
- Throughput:
  - RATIO=1: one beat per cycle sustained while out_ready=1 and the FIFO is non-empty.
  - RATIO>1: RATIO beats per FIFO word with no inter-word bubble.
- Backpressure: out_ready low for N cycles stalls output. After the buffer fills, fifo_read_en stays 0, with at most 2 words buffered.

## Structure
- Header iob_fifo_reader.vh: RATIO, SEL_W = max(1, $clog2(RATIO)), and a buffer-occupancy width of 2.
- One sub-module, iob_fifo_reader_buf: the 2-entry buffer with occ, push/pop, and head output, parameterised by FIFO_DATA_W.
- The top level holds the credit logic, the serializer (sel), and the packet counter (bcnt).

## Test plan
- Reset: assert rst mid-stream with occ=2 → next cycle out_valid=0, out_data=0, out_last=0, fifo_read_en=0, and the old words are not emitted after release.
- Serialization, RATIO=4: FIFO holds 0x44332211, 0x88776655, out_ready=1 → beats 11,22,33,44,55,66,77,88 on consecutive cycles, starting 2 cycles after the first fifo_read_en.
- Full throughput, RATIO=1 (FIFO_DATA_W=OUT_DATA_W=8): 16 words, out_ready=1 → 16 consecutive out_valid cycles with no bubble, and fifo_read_en high for 16 consecutive cycles.
- Backpressure: out_ready=0 for 10 cycles → fifo_read_en deasserts once occ+inflight reaches 2, no word is lost or duplicated, and out_data stays constant.
- Packet marking: pkt_len=3, 7 beats → out_last on beats 3 and 6 only; pkt_len=0 → out_last never asserted.
- en gating: drop en the cycle after a read → that word is still emitted, and fifo_read_en stays 0 until en returns.
